// File: rtl/tis_tick_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tis_tick_sequencer_pkg
// Description : Interval-timer register map, control words and sequencer
//               state encoding shared by the tick sequencer slice.
// Revision    : 1.0 - initial release
// ============================================================================
package tis_tick_sequencer_pkg;

    localparam logic [2:0] c_addr_status  = 3'd0;
    localparam logic [2:0] c_addr_control = 3'd1;
    localparam logic [2:0] c_addr_periodl = 3'd2;
    localparam logic [2:0] c_addr_periodh = 3'd3;

    localparam int c_bit_ito   = 0;
    localparam int c_bit_cont  = 1;
    localparam int c_bit_start = 2;
    localparam int c_bit_stop  = 3;

    localparam logic [15:0] c_ctrl_start_word =
        16'((1 << c_bit_start) | (1 << c_bit_cont) | (1 << c_bit_ito));
    localparam logic [15:0] c_ctrl_stop_word  = 16'(1 << c_bit_stop);

    localparam logic [7:0] c_overrun_max = 8'hFF;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_WR_PL    = 4'd1,
        ST_WR_PH    = 4'd2,
        ST_WR_CTRL  = 4'd3,
        ST_RUN      = 4'd4,
        ST_ACK      = 4'd5,
        ST_ACK_WAIT = 4'd6,
        ST_STOP     = 4'd7,
        ST_CLR      = 4'd8
    } state_t;

endpackage
`default_nettype wire

// File: rtl/tis_tick_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : tis_tick_sequencer_if
// Description : Avalon-MM link between the tick sequencer and the timer slave.
// Revision    : 1.0 - initial release
// ============================================================================
interface tis_tick_sequencer_if;

    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [15:0] writedata;
    logic        irq;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  irq
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output irq
    );

endinterface
`default_nettype wire

// File: rtl/tis_tick_handshake.sv
`default_nettype none
// ============================================================================
// Module      : tis_tick_handshake
// Description : Pending-tick flag, accepted-timeout counter and optional
//               saturating overrun counter (TICK_OVERRUN_CNT_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module tis_tick_handshake
    import tis_tick_sequencer_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        i_ack,
`ifdef TICK_OVERRUN_CNT_EN
    input  logic        i_start,
    output logic [7:0]  o_overrun_count,
`endif
    input  logic        i_tick_ready,
    output logic        o_tick_valid,
    output logic [15:0] o_tick_count
);

    logic        r_pending;
    logic [15:0] r_tick_count;

    // A new timeout wins over a same-cycle acceptance so it is never lost.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pending    <= 1'b0;
            r_tick_count <= 16'd0;
        end else if (i_ack) begin
            r_pending    <= 1'b1;
            r_tick_count <= r_tick_count + 16'd1;
        end else if (r_pending && i_tick_ready) begin
            r_pending    <= 1'b0;
        end
    end

`ifdef TICK_OVERRUN_CNT_EN
    logic [7:0] r_overrun_count;
    logic       w_overrun;

    assign w_overrun = i_ack && r_pending && !i_tick_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_overrun_count <= 8'd0;
        end else if (i_start) begin
            r_overrun_count <= 8'd0;
        end else if (w_overrun && (r_overrun_count != c_overrun_max)) begin
            r_overrun_count <= r_overrun_count + 8'd1;
        end
    end

    assign o_overrun_count = r_overrun_count;
`endif

    assign o_tick_valid = r_pending;
    assign o_tick_count = r_tick_count;

endmodule
`default_nettype wire

// File: rtl/tis_tick_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tis_tick_sequencer
// Description : Avalon-MM master that programs the interval timer and turns
//               its irq into a tick_valid/tick_ready stream.
//               Optional: TICK_OVERRUN_CNT_EN adds overrun_count.
// Revision    : 1.0 - initial release
// ============================================================================
module tis_tick_sequencer
    import tis_tick_sequencer_pkg::*;
#(
    parameter int unsigned PERIOD_MIN = 2
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         run,
    input  logic [31:0]                  cfg_period,
    input  logic                         cfg_load,
    tis_tick_sequencer_if.master         bus,
    output logic                         tick_valid,
    input  logic                         tick_ready,
    output logic [15:0]                  tick_count,
`ifdef TICK_OVERRUN_CNT_EN
    output logic [7:0]                   overrun_count,
`endif
    output logic                         busy
);

    localparam logic [31:0] c_period_min = 32'(PERIOD_MIN);

    state_t      r_state;
    logic [31:0] r_period;
    logic [2:0]  r_address;
    logic        r_chipselect;
    logic        r_write_n;
    logic [15:0] r_writedata;
    logic        r_busy;
    logic [31:0] w_period;
    logic        w_ack;

    assign w_period = ((cfg_period < c_period_min) ? c_period_min : cfg_period) - 32'd1;
    assign w_ack    = (r_state == ST_RUN) && run && !cfg_load && bus.irq;

    // Bus outputs are computed from the transition so they appear in the
    // same cycle the FSM enters the corresponding write state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_period     <= 32'd0;
            r_address    <= 3'd0;
            r_chipselect <= 1'b0;
            r_write_n    <= 1'b1;
            r_writedata  <= 16'd0;
            r_busy       <= 1'b0;
        end else begin
            r_address    <= 3'd0;
            r_chipselect <= 1'b0;
            r_write_n    <= 1'b1;
            r_writedata  <= 16'd0;
            r_busy       <= 1'b1;
            case (r_state)
                ST_IDLE: begin
                    r_busy <= 1'b0;
                    if (run) begin
                        r_state      <= ST_WR_PL;
                        r_period     <= w_period;
                        r_address    <= c_addr_periodl;
                        r_chipselect <= 1'b1;
                        r_write_n    <= 1'b0;
                        r_writedata  <= w_period[15:0];
                        r_busy       <= 1'b1;
                    end
                end
                ST_WR_PL: begin
                    r_state      <= ST_WR_PH;
                    r_address    <= c_addr_periodh;
                    r_chipselect <= 1'b1;
                    r_write_n    <= 1'b0;
                    r_writedata  <= r_period[31:16];
                end
                ST_WR_PH: begin
                    r_state      <= ST_WR_CTRL;
                    r_address    <= c_addr_control;
                    r_chipselect <= 1'b1;
                    r_write_n    <= 1'b0;
                    r_writedata  <= c_ctrl_start_word;
                end
                ST_WR_CTRL: begin
                    r_state <= ST_RUN;
                    r_busy  <= 1'b0;
                end
                ST_RUN: begin
                    if (!run) begin
                        r_state      <= ST_STOP;
                        r_address    <= c_addr_control;
                        r_chipselect <= 1'b1;
                        r_write_n    <= 1'b0;
                        r_writedata  <= c_ctrl_stop_word;
                    end else if (cfg_load) begin
                        r_state      <= ST_WR_PL;
                        r_period     <= w_period;
                        r_address    <= c_addr_periodl;
                        r_chipselect <= 1'b1;
                        r_write_n    <= 1'b0;
                        r_writedata  <= w_period[15:0];
                    end else if (bus.irq) begin
                        r_state      <= ST_ACK;
                        r_address    <= c_addr_status;
                        r_chipselect <= 1'b1;
                        r_write_n    <= 1'b0;
                    end else begin
                        r_busy <= 1'b0;
                    end
                end
                // irq lingers one cycle after the status clear; skip it here.
                ST_ACK:      r_state <= ST_ACK_WAIT;
                ST_ACK_WAIT: begin
                    r_state <= ST_RUN;
                    r_busy  <= 1'b0;
                end
                ST_STOP: begin
                    r_state      <= ST_CLR;
                    r_address    <= c_addr_status;
                    r_chipselect <= 1'b1;
                    r_write_n    <= 1'b0;
                end
                ST_CLR: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef TICK_OVERRUN_CNT_EN
    logic w_start;
    assign w_start = (r_state == ST_IDLE) && run;
`endif

    tis_tick_handshake u_handshake (
        .clk             (clk),
        .reset_n         (reset_n),
        .i_ack           (w_ack),
`ifdef TICK_OVERRUN_CNT_EN
        .i_start         (w_start),
        .o_overrun_count (overrun_count),
`endif
        .i_tick_ready    (tick_ready),
        .o_tick_valid    (tick_valid),
        .o_tick_count    (tick_count)
    );

    assign bus.address    = r_address;
    assign bus.chipselect = r_chipselect;
    assign bus.write_n    = r_write_n;
    assign bus.writedata  = r_writedata;
    assign busy           = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_tis_tick_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_tis_tick_sequencer
// Description : Directed bench for tis_tick_sequencer with a behavioural
//               interval-timer slave on the Avalon link.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tis_tick_sequencer;

    logic        clk        = 1'b0;
    logic        reset_n    = 1'b0;
    logic        run        = 1'b0;
    logic        cfg_load   = 1'b0;
    logic        tick_ready = 1'b0;
    logic [31:0] cfg_period = 32'd0;
    logic        tick_valid;
    logic        busy;
    logic [15:0] tick_count;
`ifdef TICK_OVERRUN_CNT_EN
    logic [7:0]  overrun_count;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    tis_tick_sequencer_if bus ();

    tis_tick_sequencer #(.PERIOD_MIN(2)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .run           (run),
        .cfg_period    (cfg_period),
        .cfg_load      (cfg_load),
        .bus           (bus),
        .tick_valid    (tick_valid),
        .tick_ready    (tick_ready),
        .tick_count    (tick_count),
`ifdef TICK_OVERRUN_CNT_EN
        .overrun_count (overrun_count),
`endif
        .busy          (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural interval timer: counts period..0, registered irq.
    logic [31:0] t_period, t_cnt;
    logic        t_run, t_cont, t_ito, t_to;
    logic        t_wr;
    assign t_wr = bus.chipselect && !bus.write_n;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            t_period <= 32'd0; t_cnt <= 32'd0;
            t_run <= 1'b0; t_cont <= 1'b0; t_ito <= 1'b0; t_to <= 1'b0;
            bus.irq <= 1'b0;
        end else begin
            bus.irq <= t_to && t_ito;
            if (t_wr && bus.address == 3'd0) t_to <= 1'b0;
            if (t_wr && bus.address == 3'd1) begin
                t_cont <= bus.writedata[1];
                t_ito  <= bus.writedata[0];
                if (bus.writedata[2]) begin t_run <= 1'b1; t_cnt <= t_period; end
                if (bus.writedata[3]) t_run <= 1'b0;
            end else if (t_wr && bus.address == 3'd2) begin
                t_period[15:0] <= bus.writedata; t_run <= 1'b0;
            end else if (t_wr && bus.address == 3'd3) begin
                t_period[31:16] <= bus.writedata; t_run <= 1'b0;
            end else if (t_run) begin
                if (t_cnt == 32'd0) begin
                    t_to  <= 1'b1;
                    t_cnt <= t_period;
                    if (!t_cont) t_run <= 1'b0;
                end else begin
                    t_cnt <= t_cnt - 32'd1;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_wr(input string tag, input logic [2:0] a, input logic [15:0] d);
        check(tag, {11'd0, bus.chipselect, bus.write_n, bus.address, bus.writedata},
                   {11'd0, 1'b1, 1'b0, a, d});
    endtask

    task automatic check_idle_bus(input string tag);
        check(tag, {11'd0, bus.chipselect, bus.write_n, bus.address, bus.writedata},
                   {11'd0, 1'b0, 1'b1, 3'd0, 16'd0});
    endtask

    task automatic wait_tick(output int at);
        int budget = 300;
        do begin
            @(negedge clk);
            budget--;
        end while (!tick_valid && budget > 0);
        check("tick_seen", 32'(tick_valid), 32'd1);
        at = cyc;
    endtask

    initial begin
        int t0, t1, budget;
        logic [15:0] cnt_before;

        // Reset
        cfg_period = 32'd50000;
        repeat (3) @(negedge clk);
        check_idle_bus("rst_bus");
        check("rst_tick_valid", 32'(tick_valid), 32'd0);
        check("rst_tick_count", 32'(tick_count), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        check_idle_bus("idle_bus");

        // Start-up write sequence, period 50000
        run = 1'b1;
        @(negedge clk); check_wr("pl_50000", 3'd2, 16'hC34F); check("busy_pl", 32'(busy), 32'd1);
        @(negedge clk); check_wr("ph_50000", 3'd3, 16'h0000); check("busy_ph", 32'(busy), 32'd1);
        @(negedge clk); check_wr("ctrl_start", 3'd1, 16'h0007); check("busy_ctrl", 32'(busy), 32'd1);
        @(negedge clk); check_idle_bus("run_bus"); check("busy_run", 32'(busy), 32'd0);

        // Plain stop
        run = 1'b0;
        @(negedge clk); check_wr("stop_ctrl", 3'd1, 16'h0008);
        @(negedge clk); check_wr("stop_clr", 3'd0, 16'h0000);
        @(negedge clk); check_idle_bus("after_stop"); check("busy_after_stop", 32'(busy), 32'd0);

        // Period 10 with an always-ready consumer
        cfg_period = 32'd10; tick_ready = 1'b1; run = 1'b1;
        repeat (4) @(negedge clk);
        wait_tick(t0);
        for (int i = 0; i < 4; i++) begin
            wait_tick(t1);
            check("interval_10", 32'(t1 - t0), 32'd10);
            t0 = t1;
        end
        check("count_after_5", 32'(tick_count), 32'd5);
        @(negedge clk);
        check("tick_one_cycle", 32'(tick_valid), 32'd0);

        // Stalled consumer across three timeouts
        tick_ready = 1'b0;
        budget = 200;
        while (tick_count != 16'd8 && budget > 0) begin @(negedge clk); budget--; end
        check("overrun_count8", 32'(tick_count), 32'd8);
        check("overrun_valid", 32'(tick_valid), 32'd1);
`ifdef TICK_OVERRUN_CNT_EN
        check("overrun_cnt", 32'(overrun_count), 32'd2);
`endif
        tick_ready = 1'b1;
        @(negedge clk);
        check("overrun_single", 32'(tick_valid), 32'd0);
        check("overrun_hold8", 32'(tick_count), 32'd8);

        // run drops in the cycle irq rises
        budget = 200;
        while (bus.irq && budget > 0) begin @(negedge clk); budget--; end
        budget = 200;
        while (!bus.irq && budget > 0) begin @(negedge clk); budget--; end
        check("irq_seen", 32'(bus.irq), 32'd1);
        cnt_before = tick_count;
        run = 1'b0;
        @(negedge clk); check_wr("race_stop", 3'd1, 16'h0008);
        @(negedge clk);
        check("race_clr", {29'd0, bus.chipselect, bus.write_n, bus.address == 3'd0},
                          {29'd0, 1'b1, 1'b0, 1'b1});
        @(negedge clk); check_idle_bus("race_idle");
        repeat (4) @(negedge clk);
        check("race_count", 32'(tick_count), 32'(cnt_before));
        check("race_no_tick", 32'(tick_valid), 32'd0);
        check("race_busy", 32'(busy), 32'd0);

        // Clamp period 0, then reprogram to 20 while running
        cfg_period = 32'd0; run = 1'b1;
        @(negedge clk); check_wr("clamp_pl", 3'd2, 16'h0001);
        @(negedge clk); check_wr("clamp_ph", 3'd3, 16'h0000);
        @(negedge clk); check_wr("clamp_ctrl", 3'd1, 16'h0007);
        @(negedge clk); check("clamp_run", 32'(busy), 32'd0);
        cfg_period = 32'd20; cfg_load = 1'b1;
        @(negedge clk); cfg_load = 1'b0;
        check_wr("reload_pl", 3'd2, 16'h0013);
        @(negedge clk); check_wr("reload_ph", 3'd3, 16'h0000);
        @(negedge clk); check_wr("reload_ctrl", 3'd1, 16'h0007);
        wait_tick(t0);
        wait_tick(t0);
        for (int i = 0; i < 2; i++) begin
            wait_tick(t1);
            check("interval_20", 32'(t1 - t0), 32'd20);
            t0 = t1;
        end

        // cfg_load outside RUN is ignored
        run = 1'b0;
        repeat (8) @(negedge clk);
        check_idle_bus("idle_again");
        cfg_load = 1'b1;
        @(negedge clk); cfg_load = 1'b0;
        check_idle_bus("load_ignored");
        @(negedge clk);
        check_idle_bus("load_ignored2");
        check("load_ignored_busy", 32'(busy), 32'd0);

        // Asynchronous reset in the middle of a write
        run = 1'b1;
        @(negedge clk); check_wr("pre_rst_pl", 3'd2, 16'h0013);
        #1 reset_n = 1'b0;
        #1;
        check_idle_bus("async_rst_bus");
        check("async_rst_count", 32'(tick_count), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tis_tick_sequencer.md
# tis_tick_sequencer

Avalon-MM master that owns the 16-bit interval-timer slave and turns its `irq` into a clean, flow-controlled tick stream for the TIS node array. It programs the timer period, starts it in continuous mode with interrupts enabled, acknowledges each timeout by clearing the status register, and presents one `tick_valid`/`tick_ready` handshake per timeout. It sits between the timer slave and the node-array step controller, with no CPU involvement.

## Interface
- `PERIOD_MIN`, default 2: smallest accepted tick period in clocks; smaller `cfg_period` values are clamped up to it.
- `clk` in 1: single clock; also drives the timer.
- `reset_n` in 1: asynchronous, active-low reset.
- `run` in 1: level; 1 = ticking requested, 0 = stop.
- `cfg_period` in 32: clocks per tick; sampled on entry to `WR_PL`.
- `cfg_load` in 1: one-cycle pulse; reprograms the period while running.
- `irq` in 1: timer interrupt (registered in the timer).
- `address` out 3: timer register address.
- `chipselect` out 1: timer select.
- `write_n` out 1: active-low write strobe.
- `writedata` out 16: timer write data.
- `tick_valid` out 1: tick pending.
- `tick_ready` in 1: consumer accepts the tick.
- `tick_count` out 16: accepted timeouts, wraps.
- `busy` out 1: FSM not in `IDLE` or `RUN`.

## Operation
- FSM states: `IDLE`, `WR_PL`, `WR_PH`, `WR_CTRL`, `RUN`, `ACK`, `ACK_WAIT`, `STOP`, `CLR`.
- Every write state drives `chipselect=1` and `write_n=0` for exactly one cycle. The timer has no waitrequest. In all other states: `chipselect=0`, `write_n=1`, `address=0`, `writedata=0`.
- Period handling:
  - `P = max(cfg_period, PERIOD_MIN) - 1`, latched in a 32-bit register.
  - `WR_PL`: address 2, data `P[15:0]`.
  - `WR_PH`: address 3, data `P[31:16]`.
- `WR_CTRL`: address 1, data 16'h0007 (START | CONT | ITO).
- `IDLE -> WR_PL` when `run=1`. Then `WR_PL -> WR_PH -> WR_CTRL -> RUN` unconditionally.
- `RUN` transitions, in priority order:
  1. `run=0` -> `STOP`.
  2. `cfg_load` -> `WR_PL`.
  3. `irq` -> `ACK`.
- `ACK`: address 0 (status clear). In the same cycle, increment `tick_count` and set the tick-pending flag. Then `ACK -> ACK_WAIT -> RUN`. `ACK_WAIT` ignores `irq`, because the timer's `irq` stays high for one cycle after the clear.
- `STOP`: address 1, data 16'h0008 (STOP; ITO and CONT cleared). `STOP -> CLR`.
- `CLR`: address 0. `CLR -> IDLE`. A timeout in flight during stop is discarded and does not count.
- Tick handshake:
  - `tick_valid` = tick-pending flag.
  - The flag clears on the cycle `tick_valid & tick_ready`.
  - Set and clear in the same cycle: set wins; `tick_valid` stays 1 for the new tick.
- Overrun: `ACK` while a tick is already pending. `tick_valid` stays 1 and only one tick is delivered. Handling depends on the configuration macro.
- `cfg_load` in any state other than `RUN` is ignored.
- `run` falling during `WR_*`: the sequence completes, then `RUN` exits to `STOP` on the next cycle.
- `tick_count` is not cleared by stop or reprogramming; only reset clears it.

## Timing
- Reset values: `address=0`, `chipselect=0`, `write_n=1`, `writedata=0`, `tick_valid=0`, `tick_count=0`, `busy=0`, state `IDLE`, period register 0.
- All outputs are registered from state or flags.
- `run` rises in cycle N -> writes issued on cycles N+1, N+2, N+3. `RUN` is reached at N+4.
- `irq` high in `RUN` on cycle M -> status write and `tick_valid=1` at M+1. FSM is back in `RUN` at M+3.
- Minimum sustainable period: 4 clocks, because an `irq` arriving during `ACK`/`ACK_WAIT` is handled after return.
- Reset asserted mid-write: outputs return to idle values immediately (async). The timer is reset by the same `reset_n`.

## Configuration
- `TICK_OVERRUN_CNT_EN` defined:
  - Adds output `overrun_count` (8 bits, reset 0).
  - Increments once per overrun, saturates at 255.
  - Clears when `run` rises in `IDLE`.
- `TICK_OVERRUN_CNT_EN` undefined: the port is absent and overruns are silently merged into the pending tick.

## Structure
- Shared package holds:
  - Timer register addresses: `STATUS=0`, `CONTROL=1`, `PERIODL=2`, `PERIODH=3`.
  - Control bit positions: `ITO=0`, `CONT=1`, `START=2`, `STOP=3`.
  - Control words 16'h0007 and 16'h0008.
  - The FSM state enum.
- One natural sub-module, `tis_tick_handshake`: pending flag, `tick_count`, and the overrun counter. The FSM stays in the top.

## Test plan
- Reset, then `run=1` with `cfg_period=50000` -> writes (2, 16'hC34F), (3, 0), (1, 7) on consecutive cycles; `busy` high for 3 cycles.
- Paired with the real timer, period 10, `tick_ready=1` -> `tick_valid` pulses every 10 clocks; `tick_count=5` after 5 pulses.
- `tick_ready=0` for 3 timeouts -> one pending tick, `tick_count=3`. With the macro, `overrun_count=2`.
- `cfg_period=0` -> clamped; the PERIODL write carries data 1.
- `run` drops at the same cycle `irq` rises -> writes (1, 8) then (0, x); `tick_count` unchanged; returns to `IDLE`.
- `cfg_load` in `RUN` with a new period 20 -> three config writes reissued; subsequent ticks every 20 clocks.
